// File: rtl/pattern_1101_tx.sv
// Serial frame transmitter: sync word 1101, then DATA_W payload bits MSB-first, then GAP_LEN zeros.
// Optional even-parity bit after the payload when PATTERN_TX_PARITY_EN is defined.
module pattern_1101_tx #(
  parameter int DATA_W  = 8,
  parameter int GAP_LEN = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] data_in,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              dout,
  output logic              frame_active,
  output logic              frame_done
);

  // Counter sequences sync, payload and the guard gap, so it must span the largest of them.
  localparam int CNT_MAX = (DATA_W > 4) ? ((DATA_W > GAP_LEN) ? DATA_W : GAP_LEN)
                                        : ((GAP_LEN > 4) ? GAP_LEN : 4);
  localparam int CW = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] SYNC_LAST = CW'(3);
  localparam logic [CW-1:0] DATA_LAST = CW'(DATA_W - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'((GAP_LEN > 0) ? GAP_LEN - 1 : 0);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SYNC   = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_GAP    = 3'd4
  } state_t;

  localparam state_t AFTER_PAYLOAD = (GAP_LEN > 0) ? ST_GAP : ST_IDLE;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic              dout_q, dout_d;
  logic              active_q, active_d;
  logic              done_q, done_d;
`ifdef PATTERN_TX_PARITY_EN
  logic              parity_q, parity_d;
`endif

  function automatic logic sync_bit(input logic [CW-1:0] idx);
    case (idx)
      CW'(0):  sync_bit = 1'b1;
      CW'(1):  sync_bit = 1'b1;
      CW'(2):  sync_bit = 1'b0;
      default: sync_bit = 1'b1;
    endcase
  endfunction

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shreg_d  = shreg_q;
    done_d   = 1'b0;
`ifdef PATTERN_TX_PARITY_EN
    parity_d = parity_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          state_d  = ST_SYNC;
          cnt_d    = '0;
          shreg_d  = data_in;
`ifdef PATTERN_TX_PARITY_EN
          parity_d = ^data_in;
`endif
        end
      end
      ST_SYNC: begin
        if (cnt_q == SYNC_LAST) begin
          state_d = ST_DATA;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_DATA: begin
        if (cnt_q == DATA_LAST) begin
          cnt_d   = '0;
`ifdef PATTERN_TX_PARITY_EN
          state_d = ST_PARITY;
`else
          state_d = AFTER_PAYLOAD;
          done_d  = 1'b1;
`endif
        end else begin
          // Shift ahead of time so the next MSB is what gets registered onto dout.
          cnt_d   = cnt_q + CW'(1);
          shreg_d = shreg_q << 1;
        end
      end
`ifdef PATTERN_TX_PARITY_EN
      ST_PARITY: begin
        state_d = AFTER_PAYLOAD;
        cnt_d   = '0;
        done_d  = 1'b1;
      end
`endif
      ST_GAP: begin
        if (cnt_q == GAP_LAST) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so they are registered alongside it.
  always_comb begin
    dout_d   = 1'b0;
    active_d = 1'b0;
    case (state_d)
      ST_SYNC: begin
        dout_d   = sync_bit(cnt_d);
        active_d = 1'b1;
      end
      ST_DATA: begin
        dout_d   = shreg_d[DATA_W-1];
        active_d = 1'b1;
      end
`ifdef PATTERN_TX_PARITY_EN
      ST_PARITY: begin
        dout_d   = parity_d;
        active_d = 1'b1;
      end
`endif
      default: begin
        dout_d   = 1'b0;
        active_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      shreg_q  <= '0;
      dout_q   <= 1'b0;
      active_q <= 1'b0;
      done_q   <= 1'b0;
`ifdef PATTERN_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shreg_q  <= shreg_d;
      dout_q   <= dout_d;
      active_q <= active_d;
      done_q   <= done_d;
`ifdef PATTERN_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  assign in_ready     = (state_q == ST_IDLE) & ~reset;
  assign dout         = dout_q;
  assign frame_active = active_q;
  assign frame_done   = done_q;

endmodule

// File: tb/tb_pattern_1101_tx.sv
// Directed bench for pattern_1101_tx: default instance (DATA_W=8, GAP_LEN=2) plus a
// DATA_W=4/GAP_LEN=0 instance, and a 1101 Mealy detector on the serial line.
module tb_pattern_1101_tx;

`ifdef PATTERN_TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int P8 = 4 + 8 + PAR + 2 + 1;
  localparam int P4 = 4 + 4 + PAR + 0 + 1;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] data_in;
  logic       in_valid, in_ready, dout, frame_active, frame_done;
  logic [3:0] d4;
  logic       v4, rdy4, dout4, fa4, fd4;
  logic [2:0] hist;
  logic       y;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pattern_1101_tx #(.DATA_W(8), .GAP_LEN(2)) u_dut (
    .clk(clk), .reset(reset), .data_in(data_in), .in_valid(in_valid),
    .in_ready(in_ready), .dout(dout), .frame_active(frame_active), .frame_done(frame_done));

  pattern_1101_tx #(.DATA_W(4), .GAP_LEN(0)) u_dut4 (
    .clk(clk), .reset(reset), .data_in(d4), .in_valid(v4),
    .in_ready(rdy4), .dout(dout4), .frame_active(fa4), .frame_done(fd4));

  // Overlapping 1101 Mealy detector fed by dout.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) hist <= 3'b000;
    else       hist <= {hist[1:0], dout};
  end
  assign y = (hist == 3'b110) & dout;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic frame_bit(input logic [31:0] d, input int w, input int c);
    logic [3:0] s;
    logic       p;
    s = 4'b1101;
    if (c < 4) return s[3-c];
    if (c < 4 + w) return d[w-1-(c-4)];
    if (PAR == 1 && c == 4 + w) begin
      p = 1'b0;
      for (int i = 0; i < w; i++) p ^= d[i];
      return p;
    end
    return 1'b0;
  endfunction

  initial begin
    logic [15:0] vec;
    logic [7:0]  w;
    int          obs, expn;
    logic [3:0]  win;

    reset = 1'b1; data_in = 8'h00; in_valid = 1'b0; d4 = 4'h0; v4 = 1'b0;
    #1;
    chk("rst_ready", in_ready, 0);
    step(); step();
    chk("rst_dout", dout, 0);
    chk("rst_active", frame_active, 0);
    chk("rst_done", frame_done, 0);
    chk("rst_ready2", in_ready, 0);
    reset = 1'b0;
    #1;
    chk("rel_ready", in_ready, 1);

    // Single frame 0xA5 (parity of A5 is 0, so the bit vector is the same either way).
    vec = 16'b1101_1010_0101_0000;
    data_in = 8'hA5; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int c = 0; c < P8 - 1; c++) begin
      chk($sformatf("a5_dout_c%0d", c), dout, vec[15-c]);
      chk($sformatf("a5_act_c%0d", c), frame_active, (c < 12 + PAR));
      chk($sformatf("a5_done_c%0d", c), frame_done, (c == 12 + PAR));
      chk($sformatf("a5_rdy_c%0d", c), in_ready, 0);
      step();
    end
    chk("a5_rdy_idle", in_ready, 1);

    // Back-to-back 0x3C then 0xFF; data_in changes while frame 1 is on the line.
    data_in = 8'h3C; in_valid = 1'b1;
    step();
    data_in = 8'hFF;
    for (int c = 0; c < 2 * P8; c++) begin
      chk($sformatf("b2b_dout_c%0d", c), dout,
          (c < P8) ? frame_bit(32'h3C, 8, c) : frame_bit(32'hFF, 8, c - P8));
      if (c == P8 - 1) chk("b2b_rdy", in_ready, 1);
      if (c == P8) begin
        chk("b2b_act2", frame_active, 1);
        in_valid = 1'b0;
      end
      if (c < 2 * P8 - 1) step();
    end
    chk("b2b_idle_rdy", in_ready, 1);

    // DATA_W=4, GAP_LEN=0 instance, word 0xF with valid held.
`ifdef PATTERN_TX_PARITY_EN
    vec = 16'b1101_1111_0010_0000;
`else
    vec = 16'b1101_1111_0100_0000;
`endif
    d4 = 4'hF; v4 = 1'b1;
    step();
    for (int c = 0; c <= P4; c++) begin
      chk($sformatf("w4_dout_c%0d", c), dout4, vec[15-c]);
      if (c == 8 + PAR) chk("w4_done", fd4, 1);
      if (c == P4 - 1) chk("w4_rdy", rdy4, 1);
      if (c == P4) begin
        chk("w4_act2", fa4, 1);
        v4 = 1'b0;
      end
      step();
    end
    repeat (P4) step();
    chk("w4_idle", rdy4, 1);

    // Asynchronous reset in cycle 6 of a frame.
    data_in = 8'h5A; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (6) step();
    #2 reset = 1'b1;
    #1;
    chk("arst_dout", dout, 0);
    chk("arst_act", frame_active, 0);
    chk("arst_rdy", in_ready, 0);
    @(posedge clk);
    #1 reset = 1'b0;
    #1;
    chk("arst_rel_rdy", in_ready, 1);
    vec = 16'b1101_1000_0000_0000;
    data_in = 8'h81; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("arst_dout_c%0d", c), dout, vec[15-c]);
      step();
    end
    repeat (P8 - 6) step();
    chk("arst_idle", in_ready, 1);

`ifdef PATTERN_TX_PARITY_EN
    data_in = 8'h07; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int c = 0; c < 14; c++) begin
      if (c == 12) chk("par_bit", dout, 1);
      chk($sformatf("par_act_c%0d", c), frame_active, (c <= 12));
      chk($sformatf("par_done_c%0d", c), frame_done, (c == 13));
      step();
    end
    step();
    chk("par_idle", in_ready, 1);
`endif

    // Loopback into the detector with random payloads.
    for (int f = 0; f < 100; f++) begin
      w = 8'($urandom_range(0, 255));
      data_in = w; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      obs = 0; expn = 0;
      for (int c = 0; c < P8; c++) begin
        if (c == 3) chk($sformatf("lb_sync_f%0d", f), y, 1);
        if (c >= 3) begin
          if (y) obs++;
          win = {frame_bit(32'(w), 8, c - 3), frame_bit(32'(w), 8, c - 2),
                 frame_bit(32'(w), 8, c - 1), frame_bit(32'(w), 8, c)};
          if (win == 4'b1101) expn++;
        end
        if (c < P8 - 1) step();
      end
      chk($sformatf("lb_count_f%0d_w%0h", f, w), obs, expn);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
